// File: rtl/aes_key_exp.sv
// AES-128 round-key generator: expands one round key per round through a shared S-box port
// and archives all NR+1 round keys in a readable store for the decryption path.
module aes_key_exp #(
  parameter int NR = 10,
  parameter int KW = 128
) (
  input  logic          clk,
  input  logic          res,
  input  logic [2:0]    cs,
  input  logic [7:0]    cot,
  input  logic [KW-1:0] key_in,
  output logic [KW-1:0] rkey,
  output logic [31:0]   sb_in,
  input  logic [31:0]   sb_out,
  input  logic [3:0]    rk_addr,
  output logic [KW-1:0] rk_rdata,
  output logic          kvalid,
  output logic          kdone,
  output logic          kerr
);

  localparam logic [2:0] CS_RES = 3'b000;
  localparam logic [2:0] CS_ADD = 3'b001;
  localparam logic [2:0] CS_SUB = 3'b010;

  typedef enum logic [1:0] {
    PH_IDLE = 2'd0,
    PH_CAP  = 2'd1,
    PH_UPD  = 2'd2
  } phase_e;

  phase_e      phase_q, phase_d, phase_cur;
  logic [KW-1:0] rkey_q, rkey_d;
  logic [31:0] tmp_q, tmp_d;
  logic [7:0]  rcon_q, rcon_d;
  logic [7:0]  cot_q, cot_d;
  logic        kvalid_q, kvalid_d;
  logic        kdone_q, kdone_d;
  logic        kerr_q, kerr_d;

  logic          st_we;
  logic [3:0]    st_idx;
  logic [KW-1:0] st_wdata;
  logic [KW-1:0] store_q [0:NR];

  logic [31:0] w0, w1, w2, w3;
  logic [31:0] n0, n1, n2, n3;
  logic        cot_ok;
  logic        start;
  logic [7:0]  rcon_x2;

  assign w0 = rkey_q[127:96];
  assign w1 = rkey_q[95:64];
  assign w2 = rkey_q[63:32];
  assign w3 = rkey_q[31:0];

  assign n0 = w0 ^ tmp_q;
  assign n1 = w1 ^ n0;
  assign n2 = w2 ^ n1;
  assign n3 = w3 ^ n2;

  assign cot_ok  = (cot >= 8'd1) && (cot <= 8'(NR));
  assign start   = (cs == CS_SUB) && cot_ok;
  assign rcon_x2 = {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);

  // The capture step is the first SUB cycle itself, so it is decoded from IDLE rather than
  // registered; this keeps the new key ready one cycle after SUB.
  always_comb begin
    phase_cur = phase_q;
    if (phase_q == PH_IDLE && start) begin
      phase_cur = PH_CAP;
    end
  end

  always_ff @(posedge clk or negedge res) begin
    if (!res) begin
      phase_q  <= PH_IDLE;
      rkey_q   <= '0;
      tmp_q    <= '0;
      rcon_q   <= 8'h01;
      cot_q    <= '0;
      kvalid_q <= 1'b0;
      kdone_q  <= 1'b0;
      kerr_q   <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      rkey_q   <= rkey_d;
      tmp_q    <= tmp_d;
      rcon_q   <= rcon_d;
      cot_q    <= cot_d;
      kvalid_q <= kvalid_d;
      kdone_q  <= kdone_d;
      kerr_q   <= kerr_d;
    end
  end

  always_comb begin
    phase_d  = phase_q;
    rkey_d   = rkey_q;
    tmp_d    = tmp_q;
    rcon_d   = rcon_q;
    kvalid_d = kvalid_q;
    kdone_d  = kdone_q;
    kerr_d   = kerr_q;
    cot_d    = cot;
    st_we    = 1'b0;
    st_idx   = '0;
    st_wdata = rkey_q;

    if (cs == CS_RES) begin
      rkey_d   = key_in;
      rcon_d   = 8'h01;
      kvalid_d = 1'b1;
      kdone_d  = 1'b0;
      kerr_d   = 1'b0;
      phase_d  = PH_IDLE;
      cot_d    = '0;
      st_we    = 1'b1;
      st_idx   = '0;
      st_wdata = key_in;
    end else begin
      case (phase_cur)
        PH_CAP: begin
          tmp_d    = sb_out ^ {rcon_q, 24'h0};
          kvalid_d = 1'b0;
          phase_d  = PH_UPD;
        end
        PH_UPD: begin
          rkey_d   = {n0, n1, n2, n3};
          st_we    = cot_ok;
          st_idx   = cot[3:0];
          st_wdata = {n0, n1, n2, n3};
          rcon_d   = rcon_x2;
          kvalid_d = 1'b1;
          if (cot == 8'(NR)) begin
            kdone_d = 1'b1;
          end
          phase_d  = PH_IDLE;
        end
        default: begin
          phase_d = PH_IDLE;
        end
      endcase

      if (cs == CS_ADD && (phase_q != PH_IDLE || !kvalid_q)) begin
        kerr_d = 1'b1;
      end
      if (cot < cot_q) begin
        kerr_d = 1'b1;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi <= NR; gi++) begin : g_store
      always_ff @(posedge clk or negedge res) begin
        if (!res) begin
          store_q[gi] <= '0;
        end else if (st_we && st_idx == 4'(gi)) begin
          store_q[gi] <= st_wdata;
        end
      end
    end
  endgenerate

  always_comb begin
    rk_rdata = '0;
    if (int'(rk_addr) <= NR) begin
      rk_rdata = store_q[rk_addr];
    end
  end

  assign rkey   = rkey_q;
  assign sb_in  = {w3[23:0], w3[31:24]};
  assign kvalid = kvalid_q;
  assign kdone  = kdone_q;
  assign kerr   = kerr_q;

endmodule

// File: tb/tb_aes_key_exp.sv
// Directed bench for aes_key_exp: FIPS-197 key schedule, holds, protocol errors, mid-update reset.
module tb_aes_key_exp;

  localparam int NR = 10;
  localparam logic [2:0] RES = 3'b000;
  localparam logic [2:0] ADD = 3'b001;
  localparam logic [2:0] SUB = 3'b010;
  localparam logic [2:0] EXP = 3'b011;
  localparam logic [2:0] SHI = 3'b100;
  localparam logic [2:0] MIX = 3'b101;
  localparam logic [2:0] FIN = 3'b111;
  localparam logic [2:0] ILL = 3'b110;
  localparam logic [127:0] CKEY = 128'h2b7e151628aed2a6abf7158809cf4f3c;

  logic         clk = 1'b0;
  logic         res;
  logic [2:0]   cs;
  logic [7:0]   cot;
  logic [127:0] key_in;
  logic [127:0] rkey;
  logic [31:0]  sb_in;
  logic [31:0]  sb_out;
  logic [3:0]   rk_addr;
  logic [127:0] rk_rdata;
  logic         kvalid, kdone, kerr;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [7:0]   rnd;
    logic [2:0]   mid_cs;
    logic [127:0] key;
  } vec_t;
  vec_t vecs [0:NR];

  logic [7:0]    sbox [0:255];
  logic [2047:0] sbox_flat;

  always #5 clk = ~clk;

  assign sb_out = {sbox[sb_in[31:24]], sbox[sb_in[23:16]], sbox[sb_in[15:8]], sbox[sb_in[7:0]]};

  aes_key_exp #(.NR(NR), .KW(128)) dut (
    .clk(clk), .res(res), .cs(cs), .cot(cot), .key_in(key_in),
    .rkey(rkey), .sb_in(sb_in), .sb_out(sb_out), .rk_addr(rk_addr),
    .rk_rdata(rk_rdata), .kvalid(kvalid), .kdone(kdone), .kerr(kerr)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %032h expected %032h", name, act, exp);
    end
  endtask

  task automatic cyc(input logic [2:0] c, input int ct);
    cs  = c;
    cot = ct[7:0];
    @(negedge clk);
  endtask

  task automatic do_round(input int r);
    logic [31:0] w3;
    w3 = vecs[r].key[31:0];
    cyc(SUB, r);
    chk($sformatf("kvalid_cap_r%0d", r), {127'd0, kvalid}, 128'd0);
    cyc(SHI, r);
    chk($sformatf("rkey_r%0d", r), rkey, vecs[r].key);
    chk($sformatf("kvalid_upd_r%0d", r), {127'd0, kvalid}, 128'd1);
    chk($sformatf("kdone_r%0d", r), {127'd0, kdone}, {127'd0, (r == NR)});
    chk($sformatf("sb_in_r%0d", r), {96'd0, sb_in}, {96'd0, w3[23:0], w3[31:24]});
    cyc(vecs[r].mid_cs, r);
    cs = ADD;
    #1;
    chk($sformatf("rkey_add_r%0d", r), rkey, vecs[r].key);
    @(negedge clk);
    chk($sformatf("kerr_add_r%0d", r), {127'd0, kerr}, 128'd0);
    $display("round %0d rkey %032h kvalid %0b kdone %0b", r, rkey, kvalid, kdone);
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got running expected done");
    $fatal(1, "timeout");
  end

  initial begin
    sbox_flat = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
    for (int i = 0; i < 256; i++) sbox[i] = sbox_flat[2047-8*i -: 8];

    vecs[0]  = '{8'd0,  MIX, CKEY};
    vecs[1]  = '{8'd1,  MIX, 128'ha0fafe1788542cb123a339392a6c7605};
    vecs[2]  = '{8'd2,  MIX, 128'hf2c295f27a96b9435935807a7359f67f};
    vecs[3]  = '{8'd3,  MIX, 128'h3d80477d4716fe3e1e237e446d7a883b};
    vecs[4]  = '{8'd4,  MIX, 128'hef44a541a8525b7fb671253bdb0bad00};
    vecs[5]  = '{8'd5,  MIX, 128'hd4d1c6f87c839d87caf2b8bc11f915bc};
    vecs[6]  = '{8'd6,  MIX, 128'h6d88a37a110b3efddbf98641ca0093fd};
    vecs[7]  = '{8'd7,  MIX, 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f};
    vecs[8]  = '{8'd8,  MIX, 128'head27321b58dbad2312bf5607f8d292f};
    vecs[9]  = '{8'd9,  MIX, 128'hac7766f319fadc2128d12941575c006e};
    vecs[10] = '{8'd10, EXP, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};

    res = 1'b1; cs = RES; cot = '0; key_in = CKEY; rk_addr = '0;
    #2 res = 1'b0;
    #1;
    chk("rst_rkey", rkey, 128'd0);
    chk("rst_kvalid", {127'd0, kvalid}, 128'd0);
    chk("rst_kdone", {127'd0, kdone}, 128'd0);
    chk("rst_kerr", {127'd0, kerr}, 128'd0);
    chk("rst_sb_in", {96'd0, sb_in}, 128'd0);
    chk("rst_store0", rk_rdata, 128'd0);
    @(negedge clk);
    res = 1'b1;

    cyc(RES, 0);
    chk("res_rkey", rkey, CKEY);
    chk("res_kvalid", {127'd0, kvalid}, 128'd1);
    chk("res_store0", rk_rdata, CKEY);
    chk("res_kdone", {127'd0, kdone}, 128'd0);
    cyc(ADD, 0);
    chk("add0_kerr", {127'd0, kerr}, 128'd0);
    $display("round 0 rkey %032h kvalid %0b", rkey, kvalid);

    for (int r = 1; r <= NR; r++) do_round(r);

    cyc(FIN, NR);
    chk("fin_kdone", {127'd0, kdone}, 128'd1);
    for (int a = 0; a <= NR; a++) begin
      rk_addr = a[3:0];
      #1;
      chk($sformatf("store_%0d", a), rk_rdata, vecs[a].key);
      $display("store[%0d] %032h", a, rk_rdata);
    end
    rk_addr = 4'd11; #1;
    chk("store_oob11", rk_rdata, 128'd0);
    rk_addr = 4'd15; #1;
    chk("store_oob15", rk_rdata, 128'd0);

    for (int i = 0; i < 20; i++) cyc(FIN, NR);
    for (int i = 0; i < 20; i++) cyc(ILL, NR);
    rk_addr = 4'd7; #1;
    chk("hold_rkey", rkey, vecs[NR].key);
    chk("hold_store7", rk_rdata, vecs[7].key);
    chk("hold_kdone", {127'd0, kdone}, 128'd1);
    chk("hold_kerr", {127'd0, kerr}, 128'd0);
    $display("hold FIN/110 40 cycles rkey %032h", rkey);

    cyc(RES, 0);
    cyc(SUB, 0);
    cyc(SHI, 0);
    chk("sub_cot0_rkey", rkey, CKEY);
    chk("sub_cot0_kvalid", {127'd0, kvalid}, 128'd1);
    cyc(SUB, 11);
    cyc(SHI, 11);
    chk("sub_cot11_rkey", rkey, CKEY);
    chk("sub_cot11_kvalid", {127'd0, kvalid}, 128'd1);
    chk("sub_cot11_kerr", {127'd0, kerr}, 128'd0);
    $display("no-update SUB cot 0/11 rkey %032h", rkey);

    cyc(RES, 0);
    cyc(SUB, 1);
    cyc(ADD, 1);
    chk("early_add_kerr", {127'd0, kerr}, 128'd1);
    chk("early_add_rkey", rkey, vecs[1].key);
    for (int i = 0; i < 5; i++) cyc(FIN, 1);
    chk("kerr_sticky", {127'd0, kerr}, 128'd1);
    cyc(RES, 0);
    chk("kerr_clear", {127'd0, kerr}, 128'd0);
    $display("early ADD kerr sequence done kerr %0b", kerr);

    cyc(SHI, 3);
    cyc(SHI, 2);
    chk("cot_dec_kerr", {127'd0, kerr}, 128'd1);
    cyc(RES, 0);
    chk("cot_dec_clear", {127'd0, kerr}, 128'd0);
    $display("cot decrease kerr sequence done");

    for (int r = 1; r <= 4; r++) do_round(r);
    cyc(SUB, 5);
    cs = SHI; cot = 8'd5;
    #2 res = 1'b0;
    #1;
    rk_addr = 4'd5;
    #1;
    chk("mid_rst_rkey", rkey, 128'd0);
    chk("mid_rst_kvalid", {127'd0, kvalid}, 128'd0);
    chk("mid_rst_kdone", {127'd0, kdone}, 128'd0);
    chk("mid_rst_sb_in", {96'd0, sb_in}, 128'd0);
    @(negedge clk);
    chk("mid_rst_store5", rk_rdata, 128'd0);
    rk_addr = 4'd4; #1;
    chk("mid_rst_store4", rk_rdata, 128'd0);
    chk("mid_rst_rkey_hold", rkey, 128'd0);
    $display("mid-update reset rkey %032h", rkey);
    res = 1'b1;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/aes_key_exp.md
Name: aes_key_exp

Overview:
- AES-128 round-key generator, directly downstream of the round controller.
- Consumes the controller's state code cs[2:0] and round count cot[7:0], and presents the round key for the current AddRoundKey to the datapath.
- Expands one round key per round, two cycles per update. SubWord goes through a shared external 32-bit S-box port.
- Archives all 11 round keys in an internal store with a read port, for the later decryption path.

Parameters:
- NR, 10, number of rounds (key store depth is NR+1).
- KW, 128, key and round-key width in bits (fixed at 128; any other value is unsupported).

Ports:
- clk  in  1  clock, rising edge.
- res  in  1  asynchronous active-low reset.
- cs  in  3  controller state code: RES=000, ADD=001, SUB=010, EXP=011, SHI=100, MIX=101, FIN=111.
- cot  in  8  controller round count, 0..NR.
- key_in  in  128  cipher key, sampled while cs==RES.
- rkey  out  128  round key for the current round; stable throughout every ADD cycle.
- sb_in  out  32  S-box request, RotWord(w3) of rkey.
- sb_out  in  32  S-box response, combinational, byte-wise SubBytes(sb_in).
- rk_addr  in  4  key-store read index.
- rk_rdata  out  128  key-store entry rk_addr; combinational read.
- kvalid  out  1  1 = rkey matches round cot.
- kdone  out  1  1 = all NR+1 keys generated and stored.
- kerr  out  1  sticky protocol error.

Behaviour:
- Reset (res=0, asynchronous): rkey=0, tmp=0, rcon=8'h01, kvalid=0, kdone=0, kerr=0, phase=IDLE, all store entries=0. sb_in follows rkey, so it reads 0.
- Word order: w0 = rkey[127:96] … w3 = rkey[31:0]. Rotation: RotWord(w)={w[23:0],w[31:24]}; sb_in = RotWord(w3) at all times.
- cs==RES, each cycle:
  - rkey<=key_in, store[0]<=key_in, rcon<=8'h01.
  - kvalid<=1, kdone<=0, kerr<=0, phase<=IDLE.
- Update phase machine IDLE -> CAP -> UPD -> IDLE:
  - IDLE: on cs==SUB with 1<=cot<=NR, go to CAP.
  - CAP (first SUB cycle): tmp<=sb_out^{rcon,24'h0}; kvalid<=0.
  - UPD: n0=w0^tmp, n1=w1^n0, n2=w2^n1, n3=w3^n2.
    - rkey<={n0,n1,n2,n3}; store[cot]<=same value.
    - rcon<=xtime(rcon): (rcon<<1) ^ (rcon[7] ? 8'h1b : 0), truncated to 8 bits.
    - kvalid<=1; kdone<=1 when cot==NR.
- Latency: the key for round r is valid at the end of the cycle after the first SUB of round r. The controller reaches ADD at least 2 cycles after entering SUB, so the key is always ready in time.
- Holds:
  - cs==SUB when cot==0 or cot>NR: no update.
  - cs in FIN, EXP, MIX, SHI, ADD, or illegal code 110: rkey, store and rcon hold.
- kerr (sticky until cs==RES or reset) is set when:
  - cs==ADD while phase!=IDLE;
  - cs==ADD while kvalid==0;
  - cot decreases other than via RES.
- rk_addr > NR: rk_rdata=0.
- Reset asserted mid-update: everything returns to reset values; no partial key is stored.

Test Plan:
- Release reset with cs=RES, key_in=2b7e151628aed2a6abf7158809cf4f3c -> rkey equals key_in, kvalid=1, rk_rdata[0] equals key_in, rcon=01.
- Drive the full controller sequence with the reference S-box model -> round 1 rkey=a0fafe1788542cb123a339392a6c7605 before the first ADD with cot=1.
- Complete all 10 rounds -> rkey=d014f9a8c9ee2589e13f0cc8b6630ca6; kdone=1; rcon takes 01,02,04,08,10,20,40,80,1b,36 across the rounds; store[0..10] all match FIPS-197.
- Pull res low during the UPD cycle of round 5 -> all outputs return to reset values immediately; rk_rdata[5]=0.
- Force cs=ADD on the cycle right after SUB -> kerr=1, and it stays 1 until cs=RES.
- Hold cs=FIN or cs=110 for 20 cycles -> rkey and store unchanged; rk_addr=11 gives rk_rdata=0.
